// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package  : video_timing_pkg
// Desc     : Shared raster timing constants, colour-bar table, total helper.
// Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    localparam int DEF_HDISPLAY = 640;
    localparam int DEF_HFRONT   = 16;
    localparam int DEF_HSYNC    = 96;
    localparam int DEF_HBACK    = 48;
    localparam int DEF_VDISPLAY = 480;
    localparam int DEF_VBOTTOM  = 11;
    localparam int DEF_VSYNC    = 2;
    localparam int DEF_VTOP     = 31;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] COLOUR_BARS [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int calc_total(input int disp, input int front,
                                      input int sync, input int back);
        return disp + front + sync + back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : video_sync_counter
// Desc     : Raster h/v counter pair with display/sync segment decode.
// Revision : 1.0 - initial release
// ============================================================================
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int pHdisplay = DEF_HDISPLAY,
    parameter int pHfront   = DEF_HFRONT,
    parameter int pHsync    = DEF_HSYNC,
    parameter int pHback    = DEF_HBACK,
    parameter int pVdisplay = DEF_VDISPLAY,
    parameter int pVbottom  = DEF_VBOTTOM,
    parameter int pVsync    = DEF_VSYNC,
    parameter int pVtop     = DEF_VTOP,
    parameter int pCntWidth = 12
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEnable,
    output logic [pCntWidth-1:0] oHcnt,
    output logic [pCntWidth-1:0] oVcnt,
    output logic                 oDeC,
    output logic                 oHsC,
    output logic                 oVsC
);

    localparam int HTOTAL = calc_total(pHdisplay, pHfront, pHsync, pHback);
    localparam int VTOTAL = calc_total(pVdisplay, pVbottom, pVsync, pVtop);

    localparam logic [pCntWidth-1:0] H_LAST       = pCntWidth'(HTOTAL - 1);
    localparam logic [pCntWidth-1:0] V_LAST       = pCntWidth'(VTOTAL - 1);
    localparam logic [pCntWidth-1:0] H_DE_END     = pCntWidth'(pHdisplay);
    localparam logic [pCntWidth-1:0] V_DE_END     = pCntWidth'(pVdisplay);
    localparam logic [pCntWidth-1:0] H_SYNC_START = pCntWidth'(pHdisplay + pHfront);
    localparam logic [pCntWidth-1:0] H_SYNC_END   = pCntWidth'(pHdisplay + pHfront + pHsync);
    localparam logic [pCntWidth-1:0] V_SYNC_START = pCntWidth'(pVdisplay + pVbottom);
    localparam logic [pCntWidth-1:0] V_SYNC_END   = pCntWidth'(pVdisplay + pVbottom + pVsync);
    localparam logic [pCntWidth-1:0] CNT_ONE      = pCntWidth'(1);

    generate
        if ((HTOTAL - 1) >= (1 << pCntWidth) || (VTOTAL - 1) >= (1 << pCntWidth)) begin : g_width_check
            $error("video_sync_counter: pCntWidth too small for Htotal/Vtotal");
        end
    endgenerate

    logic [pCntWidth-1:0] hcnt_q, hcnt_d;
    logic [pCntWidth-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!iEnable) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_ONE;
        end else begin
            hcnt_d = hcnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // vsync decodes on vcnt alone so it spans whole lines
    assign oHcnt = hcnt_q;
    assign oVcnt = vcnt_q;
    assign oDeC  = (hcnt_q < H_DE_END) && (vcnt_q < V_DE_END);
    assign oHsC  = (hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END);
    assign oVsC  = (vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Desc     : HDMI/DVI raster timing with upstream pixel pull and underflow
//            tracking. Define VIDEO_TEST_PATTERN_EN for internal colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   pHdisplay   = DEF_HDISPLAY,
    parameter int   pHfront     = DEF_HFRONT,
    parameter int   pHsync      = DEF_HSYNC,
    parameter int   pHback      = DEF_HBACK,
    parameter int   pVdisplay   = DEF_VDISPLAY,
    parameter int   pVbottom    = DEF_VBOTTOM,
    parameter int   pVsync      = DEF_VSYNC,
    parameter int   pVtop       = DEF_VTOP,
    parameter logic pSyncPol    = SYNC_ACTIVE_LOW,
    parameter int   pPixelWidth = 24,
    parameter int   pCntWidth   = 12
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iEnable,
    input  logic [pPixelWidth-1:0] iPixData,
    input  logic                   iPixValid,
    output logic                   oPixReady,
    output logic [pPixelWidth-1:0] oPixData,
    output logic                   oDe,
    output logic                   oHsync,
    output logic                   oVsync,
    output logic                   oFrameStart,
    output logic                   oUnderflow,
    output logic [15:0]            oUnderflowCnt
);

    localparam logic SYNC_IDLE = ~pSyncPol;

    logic [pCntWidth-1:0] hcnt;
    logic [pCntWidth-1:0] vcnt;
    logic                 de_c;
    logic                 hs_c;
    logic                 vs_c;

    video_sync_counter #(
        .pHdisplay (pHdisplay),
        .pHfront   (pHfront),
        .pHsync    (pHsync),
        .pHback    (pHback),
        .pVdisplay (pVdisplay),
        .pVbottom  (pVbottom),
        .pVsync    (pVsync),
        .pVtop     (pVtop),
        .pCntWidth (pCntWidth)
    ) u_sync_counter (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEnable (iEnable),
        .oHcnt   (hcnt),
        .oVcnt   (vcnt),
        .oDeC    (de_c),
        .oHsC    (hs_c),
        .oVsC    (vs_c)
    );

    logic [pPixelWidth-1:0] pix_src;
    logic                   pix_avail;
    logic                   starve;

`ifdef VIDEO_TEST_PATTERN_EN
    logic [pCntWidth+2:0] bar_num;
    logic [2:0]           bar;

    assign bar_num   = {hcnt, 3'b000} / (pCntWidth+3)'(pHdisplay);
    assign bar       = bar_num[2:0];
    assign pix_src   = pPixelWidth'(COLOUR_BARS[bar]);
    assign pix_avail = 1'b1;
    assign oPixReady = 1'b0;
`else
    assign pix_src   = iPixData;
    assign pix_avail = iPixValid;
    assign oPixReady = de_c && iEnable;
`endif

    // a missed pixel is dropped, not replayed: the raster never stalls
    assign starve = iEnable && de_c && !pix_avail;

    logic                   de_q, de_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   fs_q, fs_d;
    logic [pPixelWidth-1:0] pix_q, pix_d;
    logic                   uf_q, uf_d;
    logic [15:0]            ufcnt_q, ufcnt_d;

    always_comb begin
        de_d    = 1'b0;
        hs_d    = SYNC_IDLE;
        vs_d    = SYNC_IDLE;
        fs_d    = 1'b0;
        pix_d   = '0;
        uf_d    = uf_q;
        ufcnt_d = ufcnt_q;
        if (iEnable) begin
            de_d = de_c;
            hs_d = hs_c ? pSyncPol : SYNC_IDLE;
            vs_d = vs_c ? pSyncPol : SYNC_IDLE;
            fs_d = (hcnt == '0) && (vcnt == '0);
            if (de_c && pix_avail) begin
                pix_d = pix_src;
            end
        end
        if (starve) begin
            uf_d = 1'b1;
            if (ufcnt_q != 16'hFFFF) begin
                ufcnt_d = ufcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            de_q    <= 1'b0;
            hs_q    <= SYNC_IDLE;
            vs_q    <= SYNC_IDLE;
            fs_q    <= 1'b0;
            pix_q   <= '0;
            uf_q    <= 1'b0;
            ufcnt_q <= '0;
        end else begin
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            pix_q   <= pix_d;
            uf_q    <= uf_d;
            ufcnt_q <= ufcnt_d;
        end
    end

    assign oDe           = de_q;
    assign oHsync        = hs_q;
    assign oVsync        = vs_q;
    assign oFrameStart   = fs_q;
    assign oPixData      = pix_q;
    assign oUnderflow    = uf_q;
    assign oUnderflowCnt = ufcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Desc     : Self-checking bench for video_timing_gen (50/2/2/2 raster).
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int HT    = 56;
    localparam int VT    = 56;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        valid = 1'b1;
    logic [23:0] data = 24'd1;

    logic        rdy, o_de, o_hs, o_vs, o_fs, o_uf;
    logic [23:0] o_pix;
    logic [15:0] o_cnt;

    logic        sat_rst = 1'b1;
    logic        s_rdy, s_de, s_hs, s_vs, s_fs, s_uf;
    logic [23:0] s_pix;
    logic [15:0] s_cnt;
    logic        sat_done = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .pHdisplay(50), .pHfront(2), .pHsync(2), .pHback(2),
        .pVdisplay(50), .pVbottom(2), .pVsync(2), .pVtop(2),
        .pSyncPol(1'b0), .pPixelWidth(24), .pCntWidth(12)
    ) dut (
        .iClk(clk), .iRst(rst), .iEnable(en), .iPixData(data), .iPixValid(valid),
        .oPixReady(rdy), .oPixData(o_pix), .oDe(o_de), .oHsync(o_hs), .oVsync(o_vs),
        .oFrameStart(o_fs), .oUnderflow(o_uf), .oUnderflowCnt(o_cnt)
    );

    // large-display instance permanently starved, to reach counter saturation
    video_timing_gen #(
        .pHdisplay(250), .pHfront(1), .pHsync(1), .pHback(1),
        .pVdisplay(250), .pVbottom(1), .pVsync(1), .pVtop(1),
        .pSyncPol(1'b0), .pPixelWidth(24), .pCntWidth(12)
    ) u_sat (
        .iClk(clk), .iRst(sat_rst), .iEnable(1'b1), .iPixData(24'd0), .iPixValid(1'b0),
        .oPixReady(s_rdy), .oPixData(s_pix), .oDe(s_de), .oHsync(s_hs), .oVsync(s_vs),
        .oFrameStart(s_fs), .oUnderflow(s_uf), .oUnderflowCnt(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame drives everything
    int          pos = 0;
    logic        m_acc = 1'b0;
    logic        e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0, e_uf = 1'b0;
    logic [23:0] e_pix = '0;
    logic [15:0] e_cnt = '0;

    always @(posedge clk or posedge rst) begin
        int h, v;
        logic de;
        if (rst) begin
            pos = 0; m_acc = 0;
            e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_pix = '0; e_uf = 0; e_cnt = '0;
        end else if (!en) begin
            pos = 0; m_acc = 0;
            e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_pix = '0;
        end else begin
            h = pos % HT;
            v = pos / HT;
            de = (h < 50) && (v < 50);
            e_de = de;
            e_hs = !(h >= 52 && h < 54);
            e_vs = !(v >= 52 && v < 54);
            e_fs = (pos == 0);
            m_acc = de && valid;
            e_pix = (de && valid) ? data : 24'd0;
            if (de && !valid) begin
                e_uf = 1;
                if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            end
            pos = (pos + 1) % FRAME;
        end
    end

    // Per-cycle compare plus frame-level statistics
    int   ncyc = 0, fs_cyc = 0, de_n = 0, hs_n = 0, vs_n = 0;
    logic in_frame = 1'b0;
    logic hs_prev = 1'b1;

    always @(negedge clk) begin
        ncyc++;
        chk("de", o_de, e_de);
        chk("hsync", o_hs, e_hs);
        chk("vsync", o_vs, e_vs);
        chk("pixdata", o_pix, e_pix);
        chk("framestart", o_fs, e_fs);
        chk("uf_flag", o_uf, e_uf);
        chk("uf_cnt", o_cnt, e_cnt);
        chk("pixready", rdy, en && ((pos % HT) < 50) && ((pos / HT) < 50));
        if (rst || !en) begin
            in_frame = 0;
        end else if (o_fs) begin
            if (in_frame) begin
                chk("frame_len", ncyc - fs_cyc, FRAME);
                chk("de_per_frame", de_n, 2500);
                chk("hs_per_frame", hs_n, 112);
                chk("vs_per_frame", vs_n, 112);
            end
            in_frame = 1; fs_cyc = ncyc; de_n = 0; hs_n = 0; vs_n = 0;
        end
        if (in_frame) begin
            de_n += int'(o_de);
            hs_n += int'(!o_hs);
            vs_n += int'(!o_vs);
            if (!o_hs && hs_prev && (ncyc - fs_cyc) < HT)
                chk("hsync_first_pos", ncyc - fs_cyc, 52);
        end
        hs_prev = o_hs;
    end

    // Saturation run on the starved instance
    initial begin
        int  n;
        logic r;
        n = 0;
        wait (sat_rst == 1'b0);
        for (int c = 0; c < 80000 && n < 70000; c++) begin
            @(negedge clk);
            r = s_rdy;
            @(posedge clk);
            #1;
            if (r) begin
                n++;
                if (n == 1 || n == 65534 || n == 65535 || n == 70000)
                    chk("sat_cnt", s_cnt, (n > 65535) ? 65535 : n);
            end
        end
        if (n < 70000) begin
            checks++; failures++;
            $display("FAIL sat_timeout actual=%0d required=70000", n);
        end
        chk("sat_flag", s_uf, 1);
        sat_done = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        if (m_acc) data = data + 24'd1;
    endtask

    task automatic wait_pos(input int target, input int modulo);
        int i;
        for (i = 0; i < 2 * FRAME && (pos % modulo) != target; i++) cyc();
        if ((pos % modulo) != target) begin
            checks++; failures++;
            $display("FAIL wait_pos actual=%0d required=%0d", pos, target);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_de", o_de, 0);
        chk("rst_hsync", o_hs, 1);
        chk("rst_vsync", o_vs, 1);
        chk("rst_pix", o_pix, 0);
        chk("rst_fs", o_fs, 0);
        chk("rst_uf", o_uf, 0);
        chk("rst_cnt", o_cnt, 0);
        sat_rst = 1'b0;
        rst = 1'b0;
        en = 1'b1;
        cyc();
        chk("first_fs", o_fs, 1);
        chk("first_pix", o_pix, 24'd1);

        // three starved display pixels on line 5
        wait_pos(5 * HT + 10, FRAME);
        valid = 1'b0;
        repeat (3) cyc();
        valid = 1'b1;
        chk("uf_flag_line5", o_uf, 1);
        chk("uf_cnt_line5", o_cnt, 3);
        repeat (2 * FRAME) cyc();

        repeat (1500) begin
            valid = ($urandom_range(0, 3) != 0);
            cyc();
        end
        valid = 1'b1;

        // enable dropped at vcnt 20, raised 10 cycles later
        wait_pos(20 * HT + 30, FRAME);
        en = 1'b0;
        #1;
        chk("idle_ready", rdy, 0);
        cyc();
        chk("idle_hsync", o_hs, 1);
        chk("idle_vsync", o_vs, 1);
        chk("idle_de", o_de, 0);
        repeat (9) cyc();
        en = 1'b1;
        cyc();
        chk("reenable_fs", o_fs, 1);
        repeat (2 * FRAME + 5) cyc();

        // asynchronous reset mid-line
        wait_pos(10 * HT + 20, FRAME);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_de", o_de, 0);
        chk("arst_hsync", o_hs, 1);
        chk("arst_vsync", o_vs, 1);
        chk("arst_pix", o_pix, 0);
        chk("arst_fs", o_fs, 0);
        chk("arst_uf", o_uf, 0);
        chk("arst_cnt", o_cnt, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_fs", o_fs, 1);
        repeat (FRAME + 100) cyc();

        for (int i = 0; i < 90000 && !sat_done; i++) @(posedge clk);
        if (!sat_done) begin
            checks++; failures++;
            $display("FAIL sat_done_timeout actual=0 required=1");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates HDMI/DVI raster timing (hsync, vsync, data-enable) from per-field counters.
- Pulls pixels from the upstream frame/line buffer through a valid/ready handshake.
- Drives timing and pixel data, aligned, into the downstream TMDS encoder stage.
- Detects and counts buffer underflow so a starved upstream is visible on debug LEDs/UART.

Parameters:
- pHdisplay, 640, active pixels per line
- pHfront, 16, horizontal front porch (pixels)
- pHsync, 96, hsync width (pixels)
- pHback, 48, horizontal back porch (pixels)
- pVdisplay, 480, active lines per frame
- pVbottom, 11, vertical front porch (lines)
- pVsync, 2, vsync width (lines)
- pVtop, 31, vertical back porch (lines)
- pSyncPol, 0, sync active level (0 = active-low)
- pPixelWidth, 24, pixel bus width (RGB888)
- pCntWidth, 12, h/v counter width

Ports:
- iClk  in  1  pixel clock
- iRst  in  1  asynchronous reset, active-high
- iEnable  in  1  run raster; low holds the generator idle
- iPixData  in  pPixelWidth  pixel from upstream buffer
- iPixValid  in  1  upstream pixel available
- oPixReady  out  1  pixel consumed this cycle when iPixValid is also high
- oPixData  out  pPixelWidth  pixel to encoder
- oDe  out  1  data enable
- oHsync  out  1  horizontal sync
- oVsync  out  1  vertical sync
- oFrameStart  out  1  one-cycle pulse on the first active pixel of a frame
- oUnderflow  out  1  sticky underflow flag
- oUnderflowCnt  out  16  saturating underflow counter

Behaviour:
- Timing totals: Htotal = pHdisplay+pHfront+pHsync+pHback; Vtotal = pVdisplay+pVbottom+pVsync+pVtop.
- hcnt counts 0..Htotal-1. On wrap, hcnt returns to 0 and vcnt increments; vcnt counts 0..Vtotal-1 and wraps to 0.
- Segment order for both axes: display, front porch, sync, back porch.
- de_c = (hcnt < pHdisplay) && (vcnt < pVdisplay).
- hs_c is active for pHdisplay+pHfront <= hcnt < pHdisplay+pHfront+pHsync.
- vs_c is active for pVdisplay+pVbottom <= vcnt < pVdisplay+pVbottom+pVsync, spanning whole lines (changes at hcnt = 0).
- oPixReady = de_c && iEnable (combinational).
- Output register stage: one-cycle latency from the counters. oDe, oHsync, oVsync, oPixData and oFrameStart all change together.
- Pixel output in the registered cycle:
  - de_c && iPixValid: oPixData <= iPixData.
  - de_c && !iPixValid: underflow. oPixData <= 0 (black), oUnderflow <= 1, oUnderflowCnt increments and saturates at 16'hFFFF. The missed pixel is not replayed.
  - !de_c: oPixData <= 0.
- oFrameStart <= (hcnt == 0 && vcnt == 0 && iEnable).
- Sync polarity: the active level is pSyncPol; the idle level is ~pSyncPol.
- iEnable low (idle):
  - hcnt = vcnt = 0 and oPixReady = 0.
  - Registered outputs go to their reset state.
  - Deasserting mid-frame abandons the frame.
  - Reasserting starts a fresh frame at hcnt = vcnt = 0; the first registered cycle shows oFrameStart = 1.
- Reset values (async on iRst): hcnt = vcnt = 0; oDe = 0; oHsync = oVsync = ~pSyncPol; oPixData = 0; oFrameStart = 0; oUnderflow = 0; oUnderflowCnt = 0.
- Reset mid-line takes effect immediately. Outputs resume with a new frame on the first clock after iRst falls, provided iEnable is high.
- Underflow flag and count clear only on iRst.
- Counter widths must hold Htotal-1 and Vtotal-1. An elaboration-time check fails if either exceeds 2**pCntWidth-1.

Optional Feature:
- VIDEO_TEST_PATTERN_EN defined:
  - In display, oPixData is an internal 8-bar colour pattern: bar = hcnt*8/pHdisplay. Colours in order: white, yellow, cyan, green, magenta, red, blue, black.
  - oPixReady is tied 0; underflow is never flagged.
- Undefined: normal upstream-fed behaviour as above.

Decomposition:
- Package video_timing_pkg holds:
  - sync polarity constants;
  - the colour-bar RGB888 constant array;
  - a function computing Htotal/Vtotal from the porch parameters;
  - the default 640x480 timing constants.
- Natural sub-module: video_sync_counter, the h/v counter pair with segment decode (de_c/hs_c/vs_c). The top level adds the handshake, output register stage and underflow logic.

Test Plan:
- Sim parameters 50/2/2/2 horizontal and vertical, iPixValid always 1, incrementing data. Required response:
  - Htotal = 56 and frame = 3136 cycles.
  - 50 oDe cycles per line.
  - hsync active for hcnt 52..53 (output one cycle later).
  - oFrameStart every 3136 cycles.
  - oPixData equals the accepted sequence with no gaps.
- iPixValid low for 3 display cycles on line 5 -> 3 black pixels, oUnderflow = 1, oUnderflowCnt = 3; all other pixels correct.
- Force 70000 underflows -> oUnderflowCnt holds 16'hFFFF.
- iEnable dropped at vcnt = 20, raised 10 cycles later:
  - oPixReady = 0 and syncs idle while iEnable is low.
  - oFrameStart one cycle after the rise.
  - A full 3136-cycle frame follows.
- iRst pulsed asynchronously mid-line -> all outputs return to reset values within the same cycle; the raster restarts at 0, 0.
- With VIDEO_TEST_PATTERN_EN, pHdisplay = 64 -> 8 bars of 8 pixels each in the order above; oPixReady stays 0.
